// File: rtl/divider.sv
// Multi-cycle 32-bit restoring divider: one quotient bit per step cycle,
// signed or unsigned chosen at elaboration, with load/step/hold select control.
//
// state | meaning
// IDLE  | after reset, no division loaded
// RUN   | iterations remain, advancing one bit per step cycle
// DONE  | result (or divide-by-zero answer) written, held until next load
module divider #(
   parameter logic SIGN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic [1:0]  select,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_n;
   logic [5:0]  bits;
   logic [32:0] r;
   logic [31:0] q;
   logic [32:0] d;
   logic        neg_q, neg_r;

   logic        load, step;
   logic [31:0] dividend_abs, divisor_abs;
   logic [32:0] r_sh, r_step;
   logic [31:0] q_step, q_res, r_res;

   assign load = (select == 2'b01);
   assign step = (select == 2'b10) && (state == RUN);

   always_comb begin
      state_n = state;
      if (load) begin
         state_n = (divisor == 32'd0) ? DONE : RUN;
      end else if (step && bits == 6'd1) begin
         state_n = DONE;
      end
   end

   always_comb begin
      dividend_abs = (SIGN && dividend[31]) ? -dividend : dividend;
      divisor_abs  = (SIGN && divisor[31])  ? -divisor  : divisor;
      // Q's top bit shifts into the partial remainder each iteration
      r_sh   = {r[31:0], q[31]};
      r_step = r_sh;
      q_step = {q[30:0], 1'b0};
      if (r_sh >= d) begin
         r_step    = r_sh - d;
         q_step[0] = 1'b1;
      end
      q_res = neg_q ? -q_step : q_step;
      r_res = neg_r ? -r_step[31:0] : r_step[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bits      <= 6'd0;
         r         <= 33'd0;
         q         <= 32'd0;
         d         <= 33'd0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         quotient  <= 32'd0;
         remainder <= 32'd0;
         div_zero  <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            q     <= dividend_abs;
            d     <= {1'b0, divisor_abs};
            r     <= 33'd0;
            neg_q <= SIGN & (dividend[31] ^ divisor[31]);
            neg_r <= SIGN & dividend[31];
            bits  <= 6'd32;
            if (divisor == 32'd0) begin
               div_zero  <= 1'b1;
               quotient  <= 32'hFFFF_FFFF;
               remainder <= dividend;
            end else begin
               div_zero <= 1'b0;
            end
         end else if (step) begin
            r    <= r_step;
            q    <= q_step;
            bits <= bits - 6'd1;
            if (bits == 6'd1) begin
               quotient  <= q_res;
               remainder <= r_res;
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: a signed and an unsigned instance share stimulus
// and are compared against hand-computed quotients and remainders.
module tb_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dividend, divisor;
   logic [1:0]  select;
   logic [31:0] q_s, r_s, q_u, r_u;
   logic        busy_s, done_s, dz_s, busy_u, done_u, dz_u;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   divider #(.SIGN(1'b1)) dut_s (
      .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
      .select(select), .quotient(q_s), .remainder(r_s),
      .busy(busy_s), .done(done_s), .div_zero(dz_s)
   );

   divider #(.SIGN(1'b0)) dut_u (
      .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
      .select(select), .quotient(q_u), .remainder(r_u),
      .busy(busy_u), .done(done_u), .div_zero(dz_u)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edges(input logic [1:0] sel, input int n);
      select = sel;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] b);
      dividend = a;
      divisor  = b;
      edges(2'b01, 1);
      select = 2'b00;
   endtask

   initial begin
      reset = 1'b1; dividend = 32'd55; divisor = 32'd5; select = 2'b01;
      @(negedge clk);
      edges(2'b01, 1);
      check("rst_busy", {31'd0, busy_s}, 32'd0);
      check("rst_done", {31'd0, done_s}, 32'd0);
      check("rst_dz",   {31'd0, dz_s},   32'd0);
      check("rst_q",    q_s, 32'd0);
      check("rst_r",    r_s, 32'd0);
      reset = 1'b0;

      // 100 / 7: done exactly 33 edges after load, no intermediate values
      do_load(32'd100, 32'd7);
      edges(2'b10, 31);
      check("p7_busy_e32", {31'd0, busy_s}, 32'd1);
      check("p7_done_e32", {31'd0, done_s}, 32'd0);
      check("p7_q_hidden", q_s, 32'd0);
      edges(2'b10, 1);
      check("p7_done_e33", {31'd0, done_s}, 32'd1);
      check("p7_busy_e33", {31'd0, busy_s}, 32'd0);
      check("p7_q", q_s, 32'd14);
      check("p7_r", r_s, 32'd2);
      check("p7_dz", {31'd0, dz_s}, 32'd0);
      check("p7_q_u", q_u, 32'd14);
      check("p7_r_u", r_u, 32'd2);

      do_load(-32'sd100, 32'd7);
      check("n100_done_clr", {31'd0, done_s}, 32'd0);
      check("n100_q_hold", q_s, 32'd14);
      edges(2'b10, 32);
      check("n100_q", q_s, 32'hFFFF_FFF2);
      check("n100_r", r_s, 32'hFFFF_FFFE);
      check("n100_q_u", q_u, 32'h2492_4916);
      check("n100_r_u", r_u, 32'd2);

      do_load(32'd100, -32'sd7);
      edges(2'b10, 32);
      check("dn7_q", q_s, 32'hFFFF_FFF2);
      check("dn7_r", r_s, 32'd2);

      do_load(32'h8000_0000, 32'hFFFF_FFFF);
      edges(2'b10, 32);
      check("ovf_q", q_s, 32'h8000_0000);
      check("ovf_r", r_s, 32'd0);
      check("ovf_q_u", q_u, 32'd0);
      check("ovf_r_u", r_u, 32'h8000_0000);

      do_load(32'hFFFF_FFFF, 32'd16);
      edges(2'b10, 32);
      check("f16_q_u", q_u, 32'h0FFF_FFFF);
      check("f16_r_u", r_u, 32'd15);
      check("f16_q", q_s, 32'd0);
      check("f16_r", r_s, 32'hFFFF_FFFF);

      // divide by zero resolves on the load edge and then holds
      do_load(32'd1234, 32'd0);
      check("dz_done", {31'd0, done_s}, 32'd1);
      check("dz_flag", {31'd0, dz_s}, 32'd1);
      check("dz_busy", {31'd0, busy_s}, 32'd0);
      check("dz_q", q_s, 32'hFFFF_FFFF);
      check("dz_r", r_s, 32'd1234);
      edges(2'b10, 3);
      check("dz_hold_done", {31'd0, done_s}, 32'd1);
      check("dz_hold_r", r_s, 32'd1234);

      // 1000 / 3 with a 5-cycle stall after step 10
      do_load(32'd1000, 32'd3);
      check("stl_dz_clr", {31'd0, dz_s}, 32'd0);
      edges(2'b10, 10);
      edges(2'b00, 3);
      edges(2'b11, 2);
      check("stl_busy", {31'd0, busy_s}, 32'd1);
      edges(2'b10, 21);
      check("stl_done_e37", {31'd0, done_s}, 32'd0);
      edges(2'b10, 1);
      check("stl_done_e38", {31'd0, done_s}, 32'd1);
      check("stl_q", q_s, 32'd333);
      check("stl_r", r_s, 32'd1);
      edges(2'b00, 4);
      check("stl_hold_q", q_s, 32'd333);

      // abort by reload at step 20
      do_load(32'd1000, 32'd3);
      edges(2'b10, 20);
      do_load(32'd50, 32'd5);
      check("abt_busy", {31'd0, busy_s}, 32'd1);
      edges(2'b10, 31);
      check("abt_done_e32", {31'd0, done_s}, 32'd0);
      edges(2'b10, 1);
      check("abt_done_e33", {31'd0, done_s}, 32'd1);
      check("abt_q", q_s, 32'd10);
      check("abt_r", r_s, 32'd0);

      // reset mid-run discards the division
      do_load(32'd1000, 32'd3);
      edges(2'b10, 16);
      reset = 1'b1;
      edges(2'b10, 1);
      reset = 1'b0;
      check("mrst_busy", {31'd0, busy_s}, 32'd0);
      check("mrst_done", {31'd0, done_s}, 32'd0);
      check("mrst_q", q_s, 32'd0);
      check("mrst_r", r_s, 32'd0);
      edges(2'b10, 20);
      check("mrst_step_busy", {31'd0, busy_s}, 32'd0);
      check("mrst_step_done", {31'd0, done_s}, 32'd0);
      check("mrst_step_q", q_s, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/divider.md
# divider

Multi-cycle 32-bit divider. It produces a quotient and a remainder from a dividend and a divisor, using a restoring shift-subtract algorithm at one quotient bit per step cycle. It sits beside the multiplier in the execute stage and uses the same select-driven load/step control. Results go to the lo (quotient) and hi (remainder) registers. It works in two's-complement signed mode or in unsigned mode, fixed at elaboration.

## Interface
- SIGN, default 1'b1: 1 selects signed division (two's complement); 0 selects unsigned division.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dividend  input  32  numerator; sampled only on a load cycle.
- divisor  input  32  denominator; sampled only on a load cycle.
- select  input  2  2'b01 load/start; 2'b10 step; 2'b00 and 2'b11 hold.
- quotient  output  32  final quotient (lo); registered.
- remainder  output  32  final remainder (hi); registered.
- busy  output  1  high while iterations remain.
- done  output  1  high from result-write until the next load or reset.
- div_zero  output  1  high with done when the loaded divisor was 0.

## Operation
- States: IDLE, RUN, DONE. A 6-bit counter `bits` holds the remaining steps.
- Load (select==01, any state):
  - Capture |dividend| and |divisor|. Absolute values are taken only if SIGN=1 and bit 31 is set.
  - Record neg_q = SIGN & (dividend[31] ^ divisor[31]) and neg_r = SIGN & dividend[31].
  - Clear the 33-bit partial remainder.
  - Set bits = 32, clear done and div_zero, and go to RUN.
  - A load during RUN aborts the current division and restarts it.
- Load with divisor == 0:
  - Go directly to DONE with done=1 and div_zero=1.
  - quotient = 32'hFFFFFFFF; remainder = dividend, unmodified.
- Step (select==10 and state RUN):
  - Shift {R, Q} left by one bit; Q[31] feeds R[0].
  - If R >= D (33-bit unsigned compare), then R = R - D and Q[0] = 1.
  - Decrement bits. When bits reaches 0, write the outputs and go to DONE.
- Step in IDLE or DONE: ignored.
- Hold (select 00/11): all state frozen. In RUN this stalls the iteration with no loss.
- Result sign:
  - quotient = neg_q ? -Q : Q; remainder = neg_r ? -R[31:0] : R[31:0].
  - The remainder takes the dividend's sign, and |remainder| < |divisor|.
- Overflow, -2^31 / -1 with SIGN=1: wraps naturally to quotient 32'h80000000, remainder 0. No flag is raised.
- quotient and remainder change only on a result write, a div-by-zero load, or reset. Intermediate values are never visible.
- busy = (state == RUN).

## Timing
- Reset, at the first rising edge with reset=1:
  - state IDLE, bits 0.
  - quotient 0, remainder 0.
  - busy 0, done 0, div_zero 0.
  - reset overrides select in the same cycle.
- Reset mid-RUN: the division is discarded and every output returns to its reset value at that edge.
- Latency, with select=10 held continuously: load edge plus 32 step edges, i.e. done is high 33 edges after the load edge.
- Div-by-zero latency: done and div_zero are high after the load edge, 1 edge.
- Each stall cycle (select≠10 in RUN) adds exactly one edge to the latency.
- done stays high in DONE until the next load edge or reset. The outputs hold their values while done is high and after it.

## Test plan
- SIGN=1:
  - 100 / 7 -> quotient 14, remainder 2, done at edge 33, div_zero 0.
  - -100 / 7 -> quotient 32'hFFFFFFF2, remainder 32'hFFFFFFFE.
  - 100 / -7 -> quotient 32'hFFFFFFF2, remainder 2.
- SIGN=1:
  - 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0.
- SIGN=0 with the same operands (32'h80000000 / 32'hFFFFFFFF):
  - -> quotient 0, remainder 32'h80000000.
  - 32'hFFFFFFFF / 16 -> quotient 32'h0FFFFFFF, remainder 15.
- Divisor 0, dividend 1234:
  - Load -> next edge: done=1, div_zero=1, quotient 32'hFFFFFFFF, remainder 1234, busy 0.
- Stall and abort: 1000 / 3 with select=00 for 5 cycles after step 10 -> done at edge 38, quotient 333, remainder 1.
  - Reload 50 / 5 at step 20 -> done 33 edges after the reload, quotient 10, remainder 0.
- Reset mid-RUN:
  - Assert reset at step 16 -> busy 0, done 0, quotient 0, remainder 0.
  - Subsequent select=10 cycles are ignored.
